encoder4_2_seq: RTL and testbench

Registered 4-to-2 priority encoder with request latching and a valid/ready output handshake. It is the encoding counterpart of the 2-to-4 decoder block. Single-cycle request pulses on four one-hot lines are captured into a sticky pending register. Pending requests are then issued one at a time as 2-bit codes, highest index first, to a downstream consumer that may stall.

---
 rtl/encoder4_2_seq.sv | 80 ++++++++
 tb/tb_encoder4_2_seq.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/encoder4_2_seq.sv
// encoder4_2_seq
// Registered 4-to-2 priority encoder with sticky request latching and a
// valid/ready output handshake. Request pulses on d are collected in a
// pending register and issued one at a time, highest index first.
//
// Ports:
//   clk   in   rising-edge clock
//   rst   in   asynchronous active-high reset
//   d     in   [3:0] request lines, sampled every edge (pulses allowed)
//   ready in   downstream accepts the presented code this cycle
//   y     out  [1:0] encoded index of the issued request (valid when valid=1)
//   valid out  y carries an unconsumed code
//   ovf   out  sticky: a request was lost on an already-pending index
//   busy  out  combinational (pending != 0) | valid
module encoder4_2_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] d,
    input  logic       ready,
    output logic [1:0] y,
    output logic       valid,
    output logic       ovf,
    output logic       busy
);

    logic [3:0] pending;
    logic [1:0] sel_code;
    logic [3:0] clear_mask;
    logic       load;
    logic       lost;

    // Output slot can take a new code when empty or being drained this edge.
    assign load = (!valid || ready) && (pending != 4'b0000);

    // Priority pick from the registered pending bits only; fresh requests on
    // d never influence the code chosen in the same cycle.
    always_comb begin
        sel_code   = 2'b00;
        clear_mask = 4'b0000;
        if (pending[3]) begin
            sel_code = 2'b11;
        end else if (pending[2]) begin
            sel_code = 2'b10;
        end else if (pending[1]) begin
            sel_code = 2'b01;
        end else begin
            sel_code = 2'b00;
        end
        if (load) begin
            clear_mask = 4'b0001 << sel_code;
        end
    end

    // A re-request on the bit being cleared this edge simply re-arms it, so
    // only bits that stay pending count as lost.
    assign lost = |(d & pending & ~clear_mask);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 4'b0000;
            y       <= 2'b00;
            valid   <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            pending <= (pending & ~clear_mask) | d;
            if (load) begin
                y     <= sel_code;
                valid <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
            if (lost) begin
                ovf <= 1'b1;
            end
        end
    end

    assign busy = (pending != 4'b0000) || valid;

endmodule

// File: tb/tb_encoder4_2_seq.sv
// Testbench for encoder4_2_seq: directed scenarios followed by random
// request/ready traffic, every cycle compared against a behavioural model.
module tb_encoder4_2_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] d;
    logic       ready;
    logic [1:0] y;
    logic       valid;
    logic       ovf;
    logic       busy;

    encoder4_2_seq dut (
        .clk   (clk),
        .rst   (rst),
        .d     (d),
        .ready (ready),
        .y     (y),
        .valid (valid),
        .ovf   (ovf),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // Behavioural model: one flag per request index plus the output slot.
    bit mp[4];
    int my;
    bit mv;
    bit mo;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mp[i] = 1'b0;
        my = 0;
        mv = 1'b0;
        mo = 1'b0;
    endtask

    function automatic bit model_busy();
        bit b;
        b = mv;
        for (int i = 0; i < 4; i++) if (mp[i]) b = 1'b1;
        return b;
    endfunction

    task automatic model_edge(input logic [3:0] dv, input logic rv);
        int sel;
        bit ld;
        bit cleared;
        sel = -1;
        for (int i = 3; i >= 0; i--) if (mp[i] && sel < 0) sel = i;
        ld = (!mv || rv) && (sel >= 0);
        for (int i = 0; i < 4; i++) begin
            cleared = ld && (i == sel);
            if (dv[i] && mp[i] && !cleared) mo = 1'b1;
            mp[i] = (mp[i] && !cleared) || dv[i];
        end
        if (ld) begin
            my = sel;
            mv = 1'b1;
        end else if (mv && rv) begin
            mv = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".y"},     int'(y),     my);
        chk({tag, ".valid"}, int'(valid), int'(mv));
        chk({tag, ".ovf"},   int'(ovf),   int'(mo));
        chk({tag, ".busy"},  int'(busy),  int'(model_busy()));
    endtask

    // Drive inputs, clock once, advance the model, check 1 time unit later.
    task automatic step(input string tag, input logic [3:0] dv, input logic rv);
        d     = dv;
        ready = rv;
        @(posedge clk);
        model_edge(dv, rv);
        #1;
        check_all(tag);
    endtask

    initial begin
        // Reset with all requests high: nothing may be captured.
        rst   = 1'b1;
        d     = 4'b1111;
        ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst.y", int'(y), 0);
        chk("rst.valid", int'(valid), 0);
        chk("rst.ovf", int'(ovf), 0);
        chk("rst.busy", int'(busy), 0);
        rst = 1'b0;
        step("post_rst0", 4'b0000, 1'b1);
        step("post_rst1", 4'b0000, 1'b1);

        // Single request.
        step("single_cap", 4'b0100, 1'b1);
        chk("single_cap.valid", int'(valid), 0);
        step("single_out", 4'b0000, 1'b1);
        chk("single_out.y", int'(y), 2);
        chk("single_out.valid", int'(valid), 1);
        step("single_idle", 4'b0000, 1'b1);
        chk("single_idle.valid", int'(valid), 0);
        chk("single_idle.busy", int'(busy), 0);

        // Priority drain 1011 -> 11, 01, 00.
        step("drain_cap", 4'b1011, 1'b1);
        step("drain_3", 4'b0000, 1'b1);
        chk("drain_3.y", int'(y), 3);
        step("drain_1", 4'b0000, 1'b1);
        chk("drain_1.y", int'(y), 1);
        step("drain_0", 4'b0000, 1'b1);
        chk("drain_0.y", int'(y), 0);
        step("drain_idle", 4'b0000, 1'b1);
        chk("drain_idle.valid", int'(valid), 0);

        // Stall: code 01 must hold while ready is low.
        step("stall_cap", 4'b0011, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step("stall_hold", 4'b0000, 1'b0);
            chk("stall_hold.y", int'(y), 1);
            chk("stall_hold.valid", int'(valid), 1);
        end
        step("stall_rel", 4'b0000, 1'b1);
        chk("stall_rel.y", int'(y), 0);
        step("stall_idle", 4'b0000, 1'b1);
        chk("stall_idle.valid", int'(valid), 0);

        // Overflow: re-request index 2 while it is pending behind a stall.
        step("ovf_a", 4'b0001, 1'b0);
        step("ovf_b", 4'b0000, 1'b0);
        step("ovf_c", 4'b0100, 1'b0);
        chk("ovf_c.ovf", int'(ovf), 0);
        step("ovf_d", 4'b0100, 1'b0);
        chk("ovf_d.ovf", int'(ovf), 1);
        for (int i = 0; i < 3; i++) step("ovf_drain", 4'b0000, 1'b1);
        chk("ovf_sticky", int'(ovf), 1);

        // Reset mid-drain: valid drops without waiting for a clock edge.
        step("mid_cap", 4'b1111, 1'b1);
        step("mid_first", 4'b0000, 1'b1);
        chk("mid_first.y", int'(y), 3);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("mid_rst.valid", int'(valid), 0);
        chk("mid_rst.busy", int'(busy), 0);
        chk("mid_rst.ovf", int'(ovf), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("mid_after0", 4'b0000, 1'b1);
        step("mid_after1", 4'b0000, 1'b1);
        chk("mid_after.valid", int'(valid), 0);

        // Same-cycle re-request of the index being loaded: not an overflow.
        step("rereq_cap", 4'b0010, 1'b1);
        step("rereq_load", 4'b0010, 1'b1);
        chk("rereq_load.y", int'(y), 1);
        step("rereq_again", 4'b0000, 1'b1);
        chk("rereq_again.y", int'(y), 1);
        chk("rereq_again.valid", int'(valid), 1);
        chk("rereq_again.ovf", int'(ovf), 0);
        step("rereq_idle", 4'b0000, 1'b1);
        chk("rereq_idle.valid", int'(valid), 0);

        // Random traffic: sparse requests, mostly-ready consumer.
        for (int n = 0; n < 400; n++) begin
            logic [3:0] rd;
            logic       rr;
            rd = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            rr = ($urandom_range(0, 3) != 0);
            step("rand", rd, rr);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
